// File: rtl/vx_pipeline_perf_counters.sv
// vx_pipeline_perf_counters
// Performance-counter engine for the core pipeline. It accumulates per-cycle
// event increments and warp-occupancy popcounts into wide live counters,
// either wrapping or saturating, and keeps a sticky overflow flag per counter.
// On request it captures all counters into a shadow bank in one cycle. The
// shadow bank is served through a registered read port.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : counting enable, sampled with the increments
//   clear             : zero the live counters and the overflow flags
//   evt_inc           : per-channel increments, channel i at [i*INC_WIDTH +: INC_WIDTH]
//   active_warps      : popcount is added to counter NUM_EVENTS
//   stalled_warps     : popcount is added to counter NUM_EVENTS+1
//   snap_req/snap_done: capture request / one-cycle pulse after the shadow write
//   rd_en/rd_addr     : shadow read request and index
//   rd_valid/rd_data  : read response, one cycle after rd_en
//   ovf               : sticky overflow flag per live counter
module vx_pipeline_perf_counters #(
  parameter int unsigned NUM_EVENTS = 8,
  parameter int unsigned INC_WIDTH  = 4,
  parameter int unsigned NUM_WARPS  = 4,
  parameter int unsigned CTR_WIDTH  = 44,
  parameter int unsigned SATURATE   = 0,
  localparam int unsigned NUM_CTRS  = NUM_EVENTS + 2,
  localparam int unsigned ADDRW     = $clog2(NUM_CTRS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            clear,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0] evt_inc,
  input  logic [NUM_WARPS-1:0]            active_warps,
  input  logic [NUM_WARPS-1:0]            stalled_warps,
  input  logic                            snap_req,
  output logic                            snap_done,
  input  logic                            rd_en,
  input  logic [ADDRW-1:0]                rd_addr,
  output logic                            rd_valid,
  output logic [CTR_WIDTH-1:0]            rd_data,
  output logic [NUM_CTRS-1:0]             ovf
);

  localparam int unsigned PCW = $clog2(NUM_WARPS + 1);
  localparam int unsigned EVW = NUM_EVENTS * INC_WIDTH;

  logic [EVW-1:0]       r_evt_inc;
  logic [PCW-1:0]       r_act_cnt;
  logic [PCW-1:0]       r_stl_cnt;
  logic                 r_clear;
  logic                 r_snap;

  logic [CTR_WIDTH-1:0] r_live   [NUM_CTRS];
  logic [CTR_WIDTH-1:0] r_shadow [NUM_CTRS];

  logic [PCW-1:0]       w_act_cnt;
  logic [PCW-1:0]       w_stl_cnt;
  logic [CTR_WIDTH-1:0] w_inc    [NUM_CTRS];
  logic [CTR_WIDTH:0]   w_sum    [NUM_CTRS];
  logic [CTR_WIDTH-1:0] w_next   [NUM_CTRS];
  logic [NUM_CTRS-1:0]  w_carry;
  logic [CTR_WIDTH-1:0] w_rd_data;

  // Warp-mask popcounts
  always_comb begin
    w_act_cnt = '0;
    w_stl_cnt = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      w_act_cnt = w_act_cnt + PCW'(active_warps[i]);
      w_stl_cnt = w_stl_cnt + PCW'(stalled_warps[i]);
    end
  end

  // Stage 1: input register; disabled cycles contribute nothing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_evt_inc <= '0;
      r_act_cnt <= '0;
      r_stl_cnt <= '0;
      r_clear   <= 1'b0;
      r_snap    <= 1'b0;
    end else begin
      r_evt_inc <= enable ? evt_inc   : '0;
      r_act_cnt <= enable ? w_act_cnt : '0;
      r_stl_cnt <= enable ? w_stl_cnt : '0;
      r_clear   <= clear;
      r_snap    <= snap_req;
    end
  end

  // Stage 2 datapath: add with carry-out, optionally pinned at all-ones
  always_comb begin
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      w_inc[i] = '0;
    end
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      w_inc[i] = CTR_WIDTH'(r_evt_inc[i*INC_WIDTH +: INC_WIDTH]);
    end
    w_inc[NUM_EVENTS]     = CTR_WIDTH'(r_act_cnt);
    w_inc[NUM_EVENTS + 1] = CTR_WIDTH'(r_stl_cnt);
    w_carry = '0;
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      w_sum[i]   = {1'b0, r_live[i]} + {1'b0, w_inc[i]};
      w_carry[i] = w_sum[i][CTR_WIDTH];
      w_next[i]  = ((SATURATE != 0) && w_carry[i]) ? '1 : w_sum[i][CTR_WIDTH-1:0];
    end
  end

  // Stage 2 state: the shadow takes the sum before any clear is applied
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        r_live[i]   <= '0;
        r_shadow[i] <= '0;
      end
      ovf       <= '0;
      snap_done <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        r_live[i] <= r_clear ? '0 : w_next[i];
        if (r_snap) begin
          r_shadow[i] <= w_next[i];
        end
      end
      ovf       <= r_clear ? '0 : (ovf | w_carry);
      snap_done <= r_snap;
    end
  end

  // Shadow read mux; indices past the last counter read as zero
  always_comb begin
    w_rd_data = '0;
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      if (rd_addr == ADDRW'(i)) begin
        w_rd_data = r_shadow[i];
      end
    end
  end

  // Registered read port; data holds while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= w_rd_data;
      end
    end
  end

endmodule
